gcd_sched: RTL and testbench

- Round-robin scheduler that shares one GCD core (start/done handshake, subtract-based) between NREQ requesters.
- Arbitrates among requests, captures the operands, launches the core, waits for done, and returns the result to the granted requester with a valid/ready handshake.
- Bypasses the core for zero operands, which would otherwise never terminate by subtraction.
- Sits between the requester fabric and the GCD datapath/controller pair.

---
 rtl/gcd_pkg.sv | 19 +
 rtl/gcd_sched_rr_arbiter.sv | 37 +++
 rtl/gcd_sched.sv | 131 +++++++++++++
 tb/tb_gcd_sched.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD request scheduler: FSM encoding, default
// width and the operand packing helper.
package gcd_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE   = 2'd0;
  localparam state_t LAUNCH = 2'd1;
  localparam state_t WAIT   = 2'd2;
  localparam state_t RESP   = 2'd3;

  localparam int GCD_WIDTH = 16;

  // Bit offset of requester idx inside a packed NREQ*width operand bus.
  function automatic int op_offset(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/gcd_sched_rr_arbiter.sv
// Round-robin picker: first set request scanning upward from ptr, wrapping.
// Purely combinational; the pointer lives in the caller.
module rr_arbiter #(
  parameter int NREQ = 4,
  localparam int IW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   idx,
  output logic            found
);

  function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    s = (s >= NREQ) ? (s - NREQ) : s;
    return IW'(s);
  endfunction

  // Scan candidates in priority order; the first hit wins.
  always_comb begin
    logic [IW-1:0] cand_s;
    logic          hit_s;
    grant = {NREQ{1'b0}};
    idx   = {IW{1'b0}};
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      cand_s        = wrap_idx(ptr, k);
      hit_s         = !found && req[cand_s];
      grant[cand_s] = grant[cand_s] | hit_s;
      idx           = hit_s ? cand_s : idx;
      found         = found | hit_s;
    end
  end

endmodule

// File: rtl/gcd_sched.sv
// Shares one subtract-based GCD core among NREQ requesters with round-robin
// arbitration, a zero-operand bypass and a valid/ready result return.
module gcd_sched
  import gcd_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = GCD_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   a_in,
  input  logic [NREQ*WIDTH-1:0]   b_in,
  output logic [NREQ-1:0]         gnt,
  output logic [NREQ-1:0]         rsp_valid,
  output logic [WIDTH-1:0]        rsp_data,
  input  logic [NREQ-1:0]         rsp_ready,
  output logic                    gcd_start,
  output logic [WIDTH-1:0]        gcd_a,
  output logic [WIDTH-1:0]        gcd_b,
  input  logic                    gcd_done,
  input  logic [WIDTH-1:0]        gcd_result
);

  localparam int IW = $clog2(NREQ);

  state_t           state_r, state_nxt_s;
  logic [IW-1:0]    ptr_r, ptr_nxt_s, idx_r, idx_nxt_s, arb_idx_s;
  logic [NREQ-1:0]  arb_grant_s, gnt_nxt_s, rsp_valid_nxt_s;
  logic             arb_found_s, take_s, start_nxt_s;
  logic [WIDTH-1:0] a_hold_r, b_hold_r, a_nxt_s, b_nxt_s;
  logic [WIDTH-1:0] sel_a_s, sel_b_s, data_nxt_s;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req   (req),
    .ptr   (ptr_r),
    .grant (arb_grant_s),
    .idx   (arb_idx_s),
    .found (arb_found_s)
  );

  assign sel_a_s = a_in[op_offset(int'(arb_idx_s), WIDTH) +: WIDTH];
  assign sel_b_s = b_in[op_offset(int'(arb_idx_s), WIDTH) +: WIDTH];
  assign gcd_a   = a_hold_r;
  assign gcd_b   = b_hold_r;

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; a zero operand skips the core since subtraction never ends.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (arb_found_s) begin
          state_nxt_s = ((sel_a_s != {WIDTH{1'b0}}) && (sel_b_s != {WIDTH{1'b0}})) ? LAUNCH : RESP;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      LAUNCH: state_nxt_s = WAIT;
      WAIT: begin
        if (gcd_done) begin
          state_nxt_s = RESP;
        end else begin
          state_nxt_s = WAIT;
        end
      end
      RESP: begin
        if (rsp_ready[idx_r]) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = RESP;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Next values for the registered outputs and the hold/pointer registers.
  always_comb begin
    take_s          = (state_r == IDLE) && arb_found_s;
    idx_nxt_s       = take_s ? arb_idx_s : idx_r;
    gnt_nxt_s       = take_s ? arb_grant_s : {NREQ{1'b0}};
    start_nxt_s     = (state_nxt_s == LAUNCH);
    rsp_valid_nxt_s = (state_nxt_s == RESP) ? ({{(NREQ-1){1'b0}}, 1'b1} << idx_nxt_s)
                                            : {NREQ{1'b0}};
    a_nxt_s         = take_s ? sel_a_s : a_hold_r;
    b_nxt_s         = take_s ? sel_b_s : b_hold_r;
    if (take_s) begin
      ptr_nxt_s  = (arb_idx_s == IW'(NREQ-1)) ? {IW{1'b0}} : (arb_idx_s + 1'b1);
      data_nxt_s = sel_a_s | sel_b_s;
    end else if ((state_r == WAIT) && gcd_done) begin
      ptr_nxt_s  = ptr_r;
      data_nxt_s = gcd_result;
    end else begin
      ptr_nxt_s  = ptr_r;
      data_nxt_s = rsp_data;
    end
  end

  // Output and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_r     <= {IW{1'b0}};
      idx_r     <= {IW{1'b0}};
      a_hold_r  <= {WIDTH{1'b0}};
      b_hold_r  <= {WIDTH{1'b0}};
      rsp_data  <= {WIDTH{1'b0}};
      gnt       <= {NREQ{1'b0}};
      rsp_valid <= {NREQ{1'b0}};
      gcd_start <= 1'b0;
    end else begin
      ptr_r     <= ptr_nxt_s;
      idx_r     <= idx_nxt_s;
      a_hold_r  <= a_nxt_s;
      b_hold_r  <= b_nxt_s;
      rsp_data  <= data_nxt_s;
      gnt       <= gnt_nxt_s;
      rsp_valid <= rsp_valid_nxt_s;
      gcd_start <= start_nxt_s;
    end
  end

endmodule

// File: tb/tb_gcd_sched.sv
// Directed bench for gcd_sched with a behavioural subtract-based GCD core.
module tb_gcd_sched;

  localparam int NREQ  = 4;
  localparam int WIDTH = 16;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req, gnt, rsp_valid, rsp_ready;
  logic [NREQ*WIDTH-1:0] a_in, b_in;
  logic [WIDTH-1:0]      rsp_data, gcd_a, gcd_b, gcd_result;
  logic                  gcd_start, gcd_done;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [NREQ-1:0]  mask;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    int               idx;
    logic [WIDTH-1:0] data;
    bit               launch;
  } vec_t;

  vec_t tbl[12];

  gcd_sched #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in), .gnt(gnt),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
    .gcd_start(gcd_start), .gcd_a(gcd_a), .gcd_b(gcd_b),
    .gcd_done(gcd_done), .gcd_result(gcd_result)
  );

  always #5 clk = ~clk;

  // Reference GCD core: load on start, subtract until equal.
  logic             core_busy;
  logic [WIDTH-1:0] ca, cb;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      core_busy <= 1'b0; ca <= '0; cb <= '0;
    end else if (gcd_start) begin
      core_busy <= 1'b1; ca <= gcd_a; cb <= gcd_b;
    end else if (core_busy) begin
      if (ca == cb) core_busy <= 1'b0;
      else if (ca > cb) ca <= ca - cb;
      else cb <= cb - ca;
    end
  end
  assign gcd_done   = !core_busy && !gcd_start;
  assign gcd_result = ca;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run_job(input vec_t v, input bit hold);
    logic [NREQ-1:0]  oh;
    logic [WIDTH-1:0] sa, sb;
    int  starts;
    bit  ok, got, saw_done, pulse_chk;
    oh = 4'b0001 << v.idx;
    a_in = {NREQ{v.a}};
    b_in = {NREQ{v.b}};
    req  = v.mask;
    ok = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (gnt !== 4'b0000) begin ok = 1'b1; break; end
    end
    chk("gnt_seen", 32'(ok), 32'd1);
    if (!ok) begin req = '0; return; end
    chk("gnt_idx", 32'(gnt), 32'(oh));
    if (!hold) req = req & ~gnt;
    starts = 0; saw_done = 1'b0; got = 1'b0; pulse_chk = 1'b0;
    sa = '0; sb = '0;
    for (int c = 0; c < 3000; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 1) begin chk("gnt_pulse", 32'(gnt), 32'd0); pulse_chk = 1'b1; end
      if (gcd_start === 1'b1) begin starts++; sa = gcd_a; sb = gcd_b; end
      if (starts > 0 && gcd_done === 1'b1) saw_done = 1'b1;
      if (rsp_valid !== 4'b0000) begin got = 1'b1; break; end
    end
    chk("rsp_seen", 32'(got), 32'd1);
    if (!got) begin req = '0; return; end
    chk("rsp_valid", 32'(rsp_valid), 32'(oh));
    chk("rsp_data", 32'(rsp_data), 32'(v.data));
    chk("start_count", 32'(starts), v.launch ? 32'd1 : 32'd0);
    if (v.launch) begin
      chk("gcd_a", 32'(sa), 32'(v.a));
      chk("gcd_b", 32'(sb), 32'(v.b));
      chk("done_before_rsp", 32'(saw_done), 32'd1);
    end
    // Other requesters' ready must not release the response.
    rsp_ready = ~oh;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (!pulse_chk) begin chk("gnt_pulse", 32'(gnt), 32'd0); pulse_chk = 1'b1; end
      chk("rsp_hold_valid", 32'(rsp_valid), 32'(oh));
      chk("rsp_hold_data", 32'(rsp_data), 32'(v.data));
    end
    rsp_ready = oh;
    @(negedge clk);
    chk("rsp_release", 32'(rsp_valid), 32'd0);
    rsp_ready = '0;
    if (!hold) req = '0;
  endtask

  initial begin
    bit ok;
    tbl[0]  = '{4'b0001, 16'd12, 16'd18, 0, 16'd6,  1'b1};
    tbl[1]  = '{4'b0100, 16'd0,  16'd35, 2, 16'd35, 1'b0};
    tbl[2]  = '{4'b1001, 16'd9,  16'd6,  3, 16'd3,  1'b1};
    tbl[3]  = '{4'b1001, 16'd9,  16'd6,  0, 16'd3,  1'b1};
    tbl[4]  = '{4'b0100, 16'd0,  16'd0,  2, 16'd0,  1'b0};
    tbl[5]  = '{4'b0010, 16'd7,  16'd7,  1, 16'd7,  1'b1};
    tbl[6]  = '{4'b1111, 16'd15, 16'd25, 2, 16'd5,  1'b1};
    tbl[7]  = '{4'b1111, 16'd20, 16'd8,  3, 16'd4,  1'b1};
    tbl[8]  = '{4'b0011, 16'd5,  16'd0,  0, 16'd5,  1'b0};
    tbl[9]  = '{4'b0010, 16'd21, 16'd14, 1, 16'd7,  1'b1};
    tbl[10] = '{4'b1100, 16'd0,  16'd9,  2, 16'd9,  1'b0};
    tbl[11] = '{4'b1000, 16'd3,  16'd1,  3, 16'd1,  1'b1};

    rst = 1'b0; req = '0; rsp_ready = '0; a_in = '0; b_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_start", 32'(gcd_start), 32'd0);
    chk("rst_gcd_a", 32'(gcd_a), 32'd0);
    chk("rst_gcd_b", 32'(gcd_b), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 12; i++) run_job(tbl[i], 1'b0);

    // Fairness: all four requesters held high, pointer starts at 0.
    for (int k = 0; k < 5; k++) run_job('{4'b1111, 16'd9, 16'd6, k % 4, 16'd3, 1'b1}, 1'b1);
    req = '0;
    @(negedge clk);

    // Mid-operation reset during WAIT, then pointer must restart at 0.
    a_in = {NREQ{16'd1000}}; b_in = {NREQ{16'd1}}; req = 4'b0010;
    ok = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (gnt !== 4'b0000) begin ok = 1'b1; break; end
    end
    chk("mid_gnt", 32'(gnt), 32'b0010);
    req = '0;
    repeat (5) @(negedge clk);
    chk("mid_wait_a", 32'(gcd_a), 32'd1000);
    chk("mid_wait_valid", 32'(rsp_valid), 32'd0);
    rst = 1'b0;
    #1;
    chk("mid_rst_gnt", 32'(gnt), 32'd0);
    chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_start", 32'(gcd_start), 32'd0);
    chk("mid_rst_gcd_a", 32'(gcd_a), 32'd0);
    chk("mid_rst_gcd_b", 32'(gcd_b), 32'd0);
    chk("mid_rst_data", 32'(rsp_data), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    run_job('{4'b1010, 16'd8, 16'd4, 1, 16'd4, 1'b1}, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
